// File: rtl/rcc_prescaler_bank.sv
// Purpose : multi-channel bus-clock prescaler; one shared free-running counter
//           drives phase-aligned clock-enable pulses, one per divided period.
// Latency : ce registered one cycle after the boundary count; cfg_ack one cycle
//           after the commit edge.
// Backpr. : none on ce; ratio updates use a req/busy/ack handshake, and a
//           cfg_req arriving while busy is dropped, not queued.
//
// Ports:
//   clk_in, rst_n  - clock and async active-low reset
//   cfg_req        - ratio update request (level-sampled while idle)
//   cfg_sel        - new ratio codes, channel i at [i*SEL_W +: SEL_W]
//   ch_stop        - per-channel enable suppression (masks ce only)
//   cfg_busy       - update latched, waiting for a common period boundary
//   cfg_ack        - one-cycle pulse after the update has been committed
//   cur_sel        - currently active ratio codes
//   ce             - registered clock-enable pulses, one per channel
module rcc_prescaler_bank #(
  parameter int                CH_NUM     = 4,
  parameter int                SEL_W      = 4,
  parameter int                MAX_LOG2   = 9,
  parameter int                SKIP_EN    = 1,
  parameter int                SKIP_STAGE = 5,
  parameter logic [SEL_W-1:0]  RST_SEL    = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       cfg_req,
  input  logic [CH_NUM*SEL_W-1:0]    cfg_sel,
  input  logic [CH_NUM-1:0]          ch_stop,
  output logic                       cfg_busy,
  output logic                       cfg_ack,
  output logic [CH_NUM*SEL_W-1:0]    cur_sel,
  output logic [CH_NUM-1:0]          ce
);

  typedef logic [MAX_LOG2-1:0] cnt_t;
  typedef enum logic {IDLE, WAIT} state_t;

  // Decode a ratio code into the low-bit mask (2^k - 1) of the counter.
  // Working with masks rather than exponents keeps the boundary test a
  // simple AND-reduce, and the max over exponents becomes an OR of masks
  // because the masks of different k are nested.
  function automatic cnt_t k_mask(input logic [SEL_W-1:0] c);
    int              k;
    logic [MAX_LOG2:0] one_hot;
    if (!c[SEL_W-1]) begin
      k = 0;
    end else begin
      k = int'(32'(c[SEL_W-2:0])) + 1;
      if ((SKIP_EN != 0) && (k >= SKIP_STAGE)) k = k + 1;
    end
    if (k > MAX_LOG2) k = MAX_LOG2;
    one_hot = {{MAX_LOG2{1'b0}}, 1'b1} << k;
    return cnt_t'(one_hot - 1'b1);
  endfunction

  cnt_t                       cnt;
  cnt_t                       kmax_q;
  cnt_t                       kmax_d;
  state_t                     state_q;
  state_t                     state_d;
  logic [CH_NUM*SEL_W-1:0]    pend_sel;
  logic [CH_NUM-1:0]          bnd;
  logic                       latch;
  logic                       commit;

  // Per-channel boundary under the currently active code, plus the widest
  // period among current and requested codes (only used when latching).
  always_comb begin
    bnd    = '0;
    kmax_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      bnd[i] = &(cnt | ~k_mask(cur_sel[i*SEL_W +: SEL_W]));
      kmax_d = kmax_d | k_mask(cur_sel[i*SEL_W +: SEL_W])
                      | k_mask(cfg_sel[i*SEL_W +: SEL_W]);
    end
  end

  // Committing only where the longest old or new period ends guarantees the
  // commit edge is a boundary for every channel under both ratios.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          latch   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (&(cnt | ~kmax_q)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      state_q  <= IDLE;
      kmax_q   <= '0;
      pend_sel <= {CH_NUM{RST_SEL}};
      cur_sel  <= {CH_NUM{RST_SEL}};
      cfg_ack  <= 1'b0;
      ce       <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
      state_q <= state_d;
      cfg_ack <= commit;
      // ce uses the old code on the commit edge: the last old-ratio pulse
      // lands on the commit, the new ratio starts the following cycle.
      ce      <= bnd & ~ch_stop;
      if (latch) begin
        pend_sel <= cfg_sel;
        kmax_q   <= kmax_d;
      end
      if (commit) cur_sel <= pend_sel;
    end
  end

  assign cfg_busy = (state_q == WAIT);

endmodule

// File: tb/tb_rcc_prescaler_bank.sv
// Directed bench for rcc_prescaler_bank: a default instance plus a second
// instance with SKIP_EN=0 sharing the same stimulus. Inputs are driven and
// outputs sampled on the falling edge of clk_in.
module tb_rcc_prescaler_bank;

  logic        clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n;
  logic        cfg_req;
  logic [15:0] cfg_sel;
  logic [3:0]  ch_stop;

  logic        busy, ack;
  logic [15:0] cur;
  logic [3:0]  ce;
  logic        busy_ns, ack_ns;
  logic [15:0] cur_ns;
  logic [3:0]  ce_ns;

  int n_cmp = 0;
  int n_err = 0;
  int edges;

  rcc_prescaler_bank dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .ch_stop(ch_stop), .cfg_busy(busy), .cfg_ack(ack), .cur_sel(cur), .ce(ce)
  );

  rcc_prescaler_bank #(.SKIP_EN(0)) dut_ns (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .ch_stop(ch_stop), .cfg_busy(busy_ns), .cfg_ack(ack_ns), .cur_sel(cur_ns),
    .ce(ce_ns)
  );

  // Rising edges since reset release; edge e sees counter value e-1.
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic int pre9();
    return (edges - 1) & 511;
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 1100; t++) begin
      if (ack) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic request(input logic [15:0] sel);
    cfg_sel = sel;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
  endtask

  function automatic bit get_ce(input bit ns, input int ch);
    return ns ? ce_ns[ch] : ce[ch];
  endfunction

  // Cycles between two consecutive pulses on one channel; -1 on timeout.
  task automatic measure(input bit ns, input int ch, output int per);
    bit hit;
    per = -1;
    hit = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      tick();
      if (get_ce(ns, ch)) begin
        hit = 1'b1;
        break;
      end
    end
    if (hit) begin
      for (int t = 1; t <= 2000; t++) begin
        tick();
        if (get_ce(ns, ch)) begin
          per = t;
          break;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit  ok;
    int  n1, acks, bz, allf, per, m0, m2, off;
    logic [7:0] pat;
    bit  oth;

    rst_n = 1'b0; cfg_req = 1'b0; cfg_sel = '0; ch_stop = '0;

    // Reset defaults
    repeat (3) tick();
    chk("rst_ce",   32'(ce),   0);
    chk("rst_cur",  32'(cur),  0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack",  32'(ack),  0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("div1_ce", 32'(ce), 32'hF);
    end

    // /1 -> /4 on ch0
    request(16'h0009);
    chk("t2_busy", 32'(busy), 1);
    wait_ack(ok);
    chk("t2_ack_seen",  32'(ok), 1);
    chk("t2_ack_phase", 32'(pre9() & 3), 3);
    chk("t2_cur",       32'(cur), 32'h0009);
    chk("t2_busy_fall", 32'(busy), 0);
    chk("t2_last_old",  32'(ce[0]), 1);
    pat = '0; oth = 1'b1; acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = ce[0];
      oth    = oth & (&ce[3:1]);
      acks  += int'(ack);
    end
    chk("t2_ce0_pat", 32'(pat), 32'h88);
    chk("t2_others",  32'(oth), 1);
    chk("t2_one_ack", 32'(acks), 0);

    // ch1 to /512, then /512 -> /2 with the request made in the ack cycle
    request(16'h00F9);
    wait_ack(ok);
    chk("t3a_ack_seen", 32'(ok), 1);
    chk("t3a_phase",    32'(pre9()), 511);
    request(16'h0089);
    chk("t3_busy", 32'(busy), 1);
    n1 = 0; ok = 1'b0;
    for (int t = 0; t < 1100; t++) begin
      tick();
      if (ack) begin
        ok = 1'b1;
        break;
      end
      n1 += int'(ce[1]);
    end
    chk("t3_ack_seen",  32'(ok), 1);
    chk("t3_no_early",  32'(n1), 0);
    chk("t3_phase",     32'(pre9()), 511);
    chk("t3_old_pulse", 32'(ce[1]), 1);
    chk("t3_cur",       32'(cur), 32'h0089);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = ce[1];
    end
    chk("t3_ce1_pat", 32'(pat), 32'hAA);

    // Skip encoding: code 1100 -> /64 with skip, /32 without
    request(16'h0C89);
    wait_ack(ok);
    chk("t4_ack_seen", 32'(ok), 1);
    chk("t4_cur",      32'(cur), 32'h0C89);
    measure(1'b0, 2, per);
    chk("t4_skip_per", 32'(per), 64);
    chk("t4_ns_cur",   32'(cur_ns), 32'h0C89);
    measure(1'b1, 2, per);
    chk("t4_noskip_per", 32'(per), 32);

    // ch_stop on a /4 channel
    request(16'h0989);
    wait_ack(ok);
    chk("t5_ack_seen", 32'(ok), 1);
    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (ce[2]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_sync", 32'(ok), 1);
    ch_stop = 4'b0100;
    m0 = 0; m2 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      m0 += int'(ce[0]);
      m2 += int'(ce[2]);
    end
    ch_stop = '0;
    off = -1;
    for (int t = 11; t < 40; t++) begin
      tick();
      if (ce[2]) begin
        off = t;
        break;
      end
    end
    chk("t5_masked",   32'(m2), 0);
    chk("t5_ch0_runs", 32'(m0), 2);
    chk("t5_resume",   32'(off), 12);

    // Request during WAIT and cfg_sel change after latch are ignored
    request(16'hF888);
    cfg_sel = 16'h9999;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    wait_ack(ok);
    chk("t6_ack_seen", 32'(ok), 1);
    chk("t6_cur",      32'(cur), 32'hF888);
    bz = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bz += int'(busy);
    end
    chk("t6_ignored", 32'(bz), 0);

    // Reset while busy discards the pending update
    request(16'h9999);
    chk("t7_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_cur",  32'(cur),  0);
    chk("t7_rst_ack",  32'(ack),  0);
    tick();
    chk("t7_rst_ce", 32'(ce), 0);
    rst_n = 1'b1;
    acks = 0; bz = 0; allf = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      acks += int'(ack);
      bz   += int'(busy);
      allf += int'(ce == 4'hF);
    end
    chk("t7_no_ack",  32'(acks), 0);
    chk("t7_no_busy", 32'(bz),   0);
    chk("t7_div1",    32'(allf), 600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
